// File: rtl/cpu_fetch_seq_if.sv
// -----------------------------------------------------------------------------
// cpu_fetch_seq_if
// Memory-side bus of the opcode-fetch sequencer.
//   a      address bus (ADDR_W bits), driven by the sequencer
//   r_nw   read/not-write strobe, driven by the sequencer
//   dout   write data, driven by the sequencer
//   din    read data, driven by the memory side
//   ready  wait-state request (low stalls), driven by the memory side
// ADDR_W must match the ADDR_W of the cpu_fetch_seq instance it is bound to.
// -----------------------------------------------------------------------------
interface cpu_fetch_seq_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] a;
  logic              r_nw;
  logic [7:0]        dout;
  logic [7:0]        din;
  logic              ready;

  modport master (output a, r_nw, dout, input din, ready);
  modport slave  (input a, r_nw, dout, output din, ready);
endinterface

// File: rtl/cpu_fetch_seq.sv
// -----------------------------------------------------------------------------
// cpu_fetch_seq
// Opcode-fetch / timing sequencer for the NES CPU core. Divides clk into
// machine cycles of PHASES clocks, alternates opcode fetch (T0) with a
// decode/dummy-read cycle (T1), and parks in HALT when the fetched opcode is
// BRK_OP. While halted a debug host can read/modify PC and IR and resume.
//
// Ports
//   clk, rst_n   system clock, synchronous active-low reset
//   bus          master side of cpu_fetch_seq_if (a, r_nw, dout, din, ready)
//   brk          one-clock pulse on the first clock spent in HALT
//   halted       high while in HALT
//   dbg_resume   leave HALT (ignored unless halted)
//   dbgreg_sel   debug register select: 0 PCL, 1 PCH, 2 IR, 3 PD, 4 state,
//                5 phase, others read 8'hBD
//   dbgreg_wr    debug write strobe (sel 0..2, honoured only while halted)
//   dbgreg_in    debug write data
//   dbgreg_out   debug read data, combinational on dbgreg_sel
// -----------------------------------------------------------------------------
module cpu_fetch_seq #(
  parameter int          ADDR_W   = 16,       // 9..16
  parameter logic [15:0] RESET_PC = 16'h8000, // low ADDR_W bits used
  parameter int          PHASES   = 4,        // even, >= 2
  parameter logic [7:0]  BRK_OP   = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cpu_fetch_seq_if.master        bus,
  output logic                   brk,
  output logic                   halted,
  input  logic                   dbg_resume,
  input  logic [3:0]             dbgreg_sel,
  input  logic                   dbgreg_wr,
  input  logic [7:0]             dbgreg_in,
  output logic [7:0]             dbgreg_out
);

  localparam int PH_W = $clog2(PHASES);

  typedef enum logic [1:0] {
    ST_T0   = 2'd0,
    ST_T1   = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [PH_W-1:0]   phase, phase_n, phase_inc;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] a_q, a_n;
  logic [7:0]        ir, ir_n;
  logic [7:0]        pd, pd_n;
  logic              brk_n;
  logic              q_ready;
  logic              rdy, phi1, phi2;
  logic [15:0]       pc_ext;

  // The ready input is honoured only once it has been stable for a clock, so
  // a wait state always costs one extra clock after ready returns.
  assign rdy       = bus.ready & q_ready;
  assign phi1      = rdy && (phase == '0);
  assign phi2      = rdy && (phase == PH_W'(PHASES / 2));
  assign phase_inc = (phase == PH_W'(PHASES - 1)) ? '0 : phase + PH_W'(1);

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_n = state;
    phase_n = phase;
    pc_n    = pc;
    a_n     = a_q;
    ir_n    = ir;
    pd_n    = pd;
    brk_n   = 1'b0;

    if (rdy) begin
      case (state)
        ST_T0: begin
          phase_n = phase_inc;
          if (phi2) begin
            pd_n = bus.din;
            pc_n = pc + ADDR_W'(1);
          end
          if (phi1) begin
            state_n = ST_T1;
            ir_n    = pd;
            a_n     = pc;
          end
        end
        ST_T1: begin
          phase_n = phase_inc;
          if (phi1) begin
            if (ir == BRK_OP) begin
              state_n = ST_HALT;
              brk_n   = 1'b1;
            end else begin
              state_n = ST_T0;
              a_n     = pc;
            end
          end
        end
        ST_HALT: begin
          // Phase is held while halted. A debug write lands before a resume
          // on the same edge, so the address bus picks up the new PC.
          if (dbgreg_wr) begin
            case (dbgreg_sel)
              4'd0:    pc_n = {pc[ADDR_W-1:8], dbgreg_in};
              4'd1:    pc_n = ADDR_W'({dbgreg_in, pc[7:0]});
              4'd2:    ir_n = dbgreg_in;
              default: ;
            endcase
          end
          if (dbg_resume) begin
            state_n = ST_T0;
            phase_n = PH_W'(1);
            a_n     = pc_n;
          end
        end
        default: state_n = ST_T0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_T0;
      phase   <= PH_W'(1);
      pc      <= RESET_PC[ADDR_W-1:0];
      a_q     <= RESET_PC[ADDR_W-1:0];
      ir      <= BRK_OP;
      pd      <= '0;
      brk     <= 1'b0;
      q_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state   <= state_n;
      phase   <= phase_n;
      pc      <= pc_n;
      a_q     <= a_n;
      ir      <= ir_n;
      pd      <= pd_n;
      brk     <= brk_n;
      q_ready <= bus.ready;
    end
  end

  assign bus.a    = a_q;
  assign bus.r_nw = 1'b1;
  assign bus.dout = 8'h00;
  assign halted   = (state == ST_HALT);

  assign pc_ext = 16'(pc);

  always_comb begin
    case (dbgreg_sel)
      4'd0:    dbgreg_out = pc_ext[7:0];
      4'd1:    dbgreg_out = pc_ext[15:8];
      4'd2:    dbgreg_out = ir;
      4'd3:    dbgreg_out = pd;
      4'd4:    dbgreg_out = {6'b0, state};
      4'd5:    dbgreg_out = 8'(phase);
      default: dbgreg_out = 8'hBD;
    endcase
  end

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_fetch_seq
// Self-checking bench for cpu_fetch_seq: a 16-bit instance (RESET_PC 8000)
// carries the directed sequences, the debug-register vector table and a
// random run against an arithmetic reference model; a 12-bit instance
// (RESET_PC FFF) shows PC wrap at the narrow width.
// -----------------------------------------------------------------------------
module tb_cpu_fetch_seq;

  localparam int          P      = 4;
  localparam logic [15:0] RST_PC = 16'h8000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       brk, halted, dbg_resume, dbgreg_wr;
  logic [3:0] dbgreg_sel;
  logic [7:0] dbgreg_in, dbgreg_out;

  always #10 clk = ~clk;

  cpu_fetch_seq_if #(.ADDR_W(16)) bus ();

  cpu_fetch_seq #(.ADDR_W(16), .RESET_PC(RST_PC), .PHASES(P), .BRK_OP(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .brk(brk), .halted(halted),
    .dbg_resume(dbg_resume), .dbgreg_sel(dbgreg_sel), .dbgreg_wr(dbgreg_wr),
    .dbgreg_in(dbgreg_in), .dbgreg_out(dbgreg_out)
  );

  logic       brk12, halted12;
  logic [7:0] dbg12_out;

  cpu_fetch_seq_if #(.ADDR_W(12)) bus12 ();
  assign bus12.ready = 1'b1;
  assign bus12.din   = 8'hEA;

  cpu_fetch_seq #(.ADDR_W(12), .RESET_PC(16'h0FFF), .PHASES(P), .BRK_OP(8'h00)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12), .brk(brk12), .halted(halted12),
    .dbg_resume(1'b0), .dbgreg_sel(4'd0), .dbgreg_wr(1'b0),
    .dbgreg_in(8'h00), .dbgreg_out(dbg12_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory image seen by the directed tests: every byte is 'fill' except
  // a BRK at brk_addr.
  logic        use_mem;
  logic [7:0]  fill;
  logic [15:0] brk_addr;

  // din sampled at each rdy edge of the random run, indexed by edge number.
  logic [7:0]  din_log [0:1023];

  typedef struct {
    logic       wr;
    logic [3:0] sel;
    logic [7:0] wdata;
    logic [3:0] rsel;
    logic [7:0] exp;
  } dbg_vec_t;

  dbg_vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] addr);
    return (addr == brk_addr) ? 8'h00 : fill;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (use_mem) bus.din = mem_byte(bus.a);
  endtask

  task automatic check_rd(input string name, input logic [3:0] sel, input logic [7:0] exp);
    dbgreg_sel = sel;
    #1;
    check(name, dbgreg_out, exp);
  endtask

  task automatic wr(input logic [3:0] sel, input logic [7:0] data);
    dbgreg_sel = sel;
    dbgreg_in  = data;
    dbgreg_wr  = 1'b1;
    tick();
    dbgreg_wr  = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int k = 0;
    while (!halted && k < 64) begin
      tick();
      k++;
    end
    check({name, "_halted"}, halted, 1);
    check({name, "_brk"}, brk, 1);
  endtask

  // Reference model of a free run (no BRK fetched) after n rdy edges.
  // Edge k (0-based) meets phase (1+k)%P: phi1 at k = iP-1, phi2 at
  // k = jP + P/2 - 1. Even machine cycles are fetches that bump PC at phi2;
  // each phi1 copies PC to the address bus.
  function automatic void model(input int n, output logic [15:0] pc, output logic [15:0] a,
                                output logic [7:0] ir, output logic [7:0] pd,
                                output logic [7:0] st, output logic [7:0] ph);
    int m  = n / P;
    int c2 = (n + P / 2) / P;
    pc = RST_PC + 16'((c2 + 1) / 2);
    a  = RST_PC + 16'((m + 1) / 2);
    st = 8'(m % 2);
    ph = 8'((1 + n) % P);
    pd = 8'h00;
    if (c2 > 0) pd = din_log[((c2 - 1) / 2) * 2 * P + P / 2 - 1];
    ir = 8'h00;
    if (m > 0) begin
      int i = (m % 2 == 1) ? m : m - 1;
      ir = din_log[(i - 1) * P + P / 2 - 1];
    end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m_pc, m_a;
    logic [7:0]  m_ir, m_pd, m_st, m_ph, exp_rd;
    logic        rprev, ready_v;
    logic [7:0]  din_v;
    int          n;

    //        wr    sel    wdata  rsel   expected read
    vecs[0]  = '{1'b0, 4'd0,  8'h00, 4'd0,  8'h05};
    vecs[1]  = '{1'b0, 4'd0,  8'h00, 4'd1,  8'h80};
    vecs[2]  = '{1'b0, 4'd0,  8'h00, 4'd2,  8'h00};
    vecs[3]  = '{1'b0, 4'd0,  8'h00, 4'd3,  8'h00};
    vecs[4]  = '{1'b0, 4'd0,  8'h00, 4'd4,  8'h02};
    vecs[5]  = '{1'b0, 4'd0,  8'h00, 4'd5,  8'h01};
    vecs[6]  = '{1'b0, 4'd0,  8'h00, 4'd9,  8'hBD};
    vecs[7]  = '{1'b1, 4'd2,  8'h5A, 4'd2,  8'h5A};
    vecs[8]  = '{1'b1, 4'd3,  8'h77, 4'd3,  8'h00};
    vecs[9]  = '{1'b1, 4'd0,  8'h34, 4'd0,  8'h34};
    vecs[10] = '{1'b1, 4'd1,  8'h99, 4'd1,  8'h99};
    vecs[11] = '{1'b1, 4'd4,  8'h03, 4'd4,  8'h02};
    vecs[12] = '{1'b1, 4'd15, 8'hFF, 4'd0,  8'h34};
    vecs[13] = '{1'b0, 4'd0,  8'h00, 4'd15, 8'hBD};

    rst_n      = 1'b0;
    bus.ready  = 1'b1;
    bus.din    = 8'hEA;
    dbg_resume = 1'b0;
    dbgreg_sel = 4'd0;
    dbgreg_wr  = 1'b0;
    dbgreg_in  = 8'h00;
    use_mem    = 1'b1;
    fill       = 8'hEA;
    brk_addr   = 16'h8004;
    tick();
    tick();
    rst_n   = 1'b1;
    bus.din = mem_byte(bus.a);

    // Reset state and NOP fetch timing: 8000, 8001, 8001, 8002, 4 clks each.
    check("rst_r_nw", bus.r_nw, 1);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_brk", brk, 0);
    check_rd("rst_phase", 4'd5, 8'h01);
    check("a12_reset", bus12.a, 12'hFFF);
    check("r_nw12", bus12.r_nw, 1);
    check("dout12", bus12.dout, 8'h00);
    for (int s = 0; s < 40; s++) begin
      if (s < 16) check($sformatf("nop_a_s%0d", s), bus.a, RST_PC + 16'((s / P + 1) / 2));
      check($sformatf("run_halted_s%0d", s), halted, 0);
      if (s == 4) begin
        check("a12_wrap", bus12.a, 12'h000);
        check("pcl12_wrap", dbg12_out, 8'h00);
        check("halted12", halted12, 0);
        check("brk12", brk12, 0);
      end
      tick();
    end

    // BRK fetched at 8004 halts after its T1.
    check("brk_pulse", brk, 1);
    check("brk_halted", halted, 1);
    check("brk_a", bus.a, 16'h8005);
    tick();
    check("brk_pulse_end", brk, 0);
    check("brk_still_halted", halted, 1);

    // Debug register map and write rules while halted.
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].wr) wr(vecs[v].sel, vecs[v].wdata);
      check_rd($sformatf("dbg_vec%0d", v), vecs[v].rsel, vecs[v].exp);
    end

    // Write PCH and resume on the same edge: a picks up the new PC.
    dbgreg_sel = 4'd1;
    dbgreg_in  = 8'h12;
    dbgreg_wr  = 1'b1;
    dbg_resume = 1'b1;
    tick();
    dbgreg_wr  = 1'b0;
    dbg_resume = 1'b0;
    check("resume_a", bus.a, 16'h1234);
    check("resume_halted", halted, 0);
    check_rd("resume_phase", 4'd5, 8'h01);
    check_rd("resume_state", 4'd4, 8'h00);

    // Stall 7 clks mid-T0: 8 clks lost, a moves to 1235 on edge 12, not 4.
    for (int e = 1; e <= 12; e++) begin
      bus.ready = !(e >= 2 && e <= 8);
      tick();
      check($sformatf("stall_a_e%0d", e), bus.a, (e < 12) ? 16'h1235 - 16'd1 : 16'h1235);
      check_rd($sformatf("stall_ph_e%0d", e), 4'd5,
               (e <= 9) ? 8'd2 : (e == 10) ? 8'd3 : (e == 11) ? 8'd0 : 8'd1);
      if (e == 8)  check_rd("stall_pc_frozen", 4'd0, 8'h34);
      if (e == 11) check_rd("stall_pc_inc", 4'd0, 8'h35);
    end
    check_rd("stall_ir", 4'd2, 8'hEA);

    // Debug writes are ignored while running.
    wr(4'd0, 8'hAA);
    check_rd("run_wr_pcl", 4'd0, 8'h35);
    check_rd("run_wr_pch", 4'd1, 8'h12);

    // 16-bit wrap: halt, load FFFF, fetch a NOP.
    fill = 8'h00;
    wait_halt("halt2");
    check("halt2_a", bus.a, 16'h1236);
    wr(4'd0, 8'hFF);
    wr(4'd1, 8'hFF);
    fill       = 8'hEA;
    dbg_resume = 1'b1;
    tick();
    dbg_resume = 1'b0;
    check("wrap_a_start", bus.a, 16'hFFFF);
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) check("wrap_a_hold", bus.a, 16'hFFFF);
    end
    check("wrap_a", bus.a, 16'h0000);
    check_rd("wrap_pcl", 4'd0, 8'h00);
    check_rd("wrap_pch", 4'd1, 8'h00);

    // Reset while halted.
    fill = 8'h00;
    wait_halt("halt3");
    tick();
    check("halt3_brk_end", brk, 0);
    rst_n = 1'b0;
    tick();
    check("rst_halt_a", bus.a, RST_PC);
    check("rst_halt_halted", halted, 0);
    check("rst_halt_brk", brk, 0);
    check_rd("rst_halt_pch", 4'd1, 8'h80);
    check_rd("rst_halt_phase", 4'd5, 8'h01);

    // Random run: random ready, data, ignored debug writes and resumes.
    use_mem = 1'b0;
    tick();
    rst_n = 1'b1;
    n     = 0;
    rprev = 1'b1;
    for (int c = 0; c < 600; c++) begin
      model(n, m_pc, m_a, m_ir, m_pd, m_st, m_ph);
      dbgreg_sel = 4'($urandom_range(0, 15));
      #1;
      case (dbgreg_sel)
        4'd0:    exp_rd = m_pc[7:0];
        4'd1:    exp_rd = m_pc[15:8];
        4'd2:    exp_rd = m_ir;
        4'd3:    exp_rd = m_pd;
        4'd4:    exp_rd = m_st;
        4'd5:    exp_rd = m_ph;
        default: exp_rd = 8'hBD;
      endcase
      check($sformatf("rand_a_c%0d", c), bus.a, m_a);
      check($sformatf("rand_dbg_c%0d_sel%0d", c, dbgreg_sel), dbgreg_out, exp_rd);
      check($sformatf("rand_halt_c%0d", c), {brk, halted}, 2'b00);
      ready_v    = ($urandom_range(0, 3) != 0);
      din_v      = 8'($urandom_range(1, 255));
      bus.ready  = ready_v;
      bus.din    = din_v;
      dbgreg_wr  = 1'($urandom_range(0, 1));
      dbgreg_in  = 8'($urandom_range(0, 255));
      dbg_resume = 1'($urandom_range(0, 1));
      if (ready_v && rprev) begin
        din_log[n] = din_v;
        n++;
      end
      rprev = ready_v;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
